// File: rtl/csr_timer_bank.sv
// Bank of NUM_CH countdown timers sharing one prescaler, mapped onto the CSR access bus.
// Each channel has its own enable/periodic/initval, pending bit, and a fixed-priority irq encoder.
module csr_timer_bank #(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter int          PRE_W    = 8,
    parameter logic [13:0] CSR_BASE = 14'h0040
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [13:0]       csr_num,
    input  logic              csr_we,
    input  logic [31:0]       csr_wmask,
    input  logic [31:0]       csr_wvalue,
    output logic [31:0]       csr_rvalue,
    output logic              csr_hit,
    output logic [NUM_CH-1:0] timer_pend,
    output logic              irq_any,
    output logic [2:0]        irq_id
);

    localparam logic [13:0] CH_SPAN = 14'(4 * NUM_CH);

    logic [13:0]       off;
    logic              in_map;
    logic              is_chan;
    logic              is_tpre;
    logic              is_tie;
    logic [11:0]       ch_sel;
    logic [1:0]        slot;

    logic [PRE_W-1:0]  tpre;
    logic [PRE_W-1:0]  pre_cnt;
    logic [NUM_CH-1:0] tie;
    logic              tpre_we;
    logic              tie_we;
    logic              tick;

    logic [CNT_W-1:0]  cnt_arr [NUM_CH];
    logic [CNT_W-1:0]  cfg_arr [NUM_CH];
    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] masked;

    assign off     = csr_num - CSR_BASE;
    assign in_map  = (csr_num >= CSR_BASE) && (off <= CH_SPAN + 14'd1);
    assign is_chan = in_map && (off < CH_SPAN);
    assign is_tpre = in_map && (off == CH_SPAN);
    assign is_tie  = in_map && (off == CH_SPAN + 14'd1);
    assign ch_sel  = off[13:2];
    assign slot    = off[1:0];

    assign tpre_we = csr_we && is_tpre;
    assign tie_we  = csr_we && is_tie;
    // A TPRE write restarts the prescaler phase and swallows that cycle's tick.
    assign tick    = (pre_cnt == tpre) && !tpre_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tpre    <= '0;
            pre_cnt <= '0;
            tie     <= '0;
        end else begin
            if (tpre_we) begin
                tpre    <= (csr_wmask[PRE_W-1:0] & csr_wvalue[PRE_W-1:0]) |
                           (~csr_wmask[PRE_W-1:0] & tpre);
                pre_cnt <= '0;
            end else if (pre_cnt == tpre) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (tie_we) begin
                tie <= (csr_wmask[NUM_CH-1:0] & csr_wvalue[NUM_CH-1:0]) |
                       (~csr_wmask[NUM_CH-1:0] & tie);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             en_q;
        logic             per_q;
        logic             pend_q;
        logic [CNT_W-3:0] init_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cfg_old;
        logic [CNT_W-1:0] cfg_new;
        logic             tcfg_we;
        logic             clr_we;
        logic             expire;

        assign cfg_old = {init_q, per_q, en_q};
        assign cfg_new = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0]) |
                         (~csr_wmask[CNT_W-1:0] & cfg_old);
        assign tcfg_we = csr_we && is_chan && (ch_sel == 12'(i)) && (slot == 2'd0);
        assign clr_we  = csr_we && is_chan && (ch_sel == 12'(i)) && (slot == 2'd2) &&
                         csr_wmask[0] && csr_wvalue[0];
        // Any TCFG write owns the counter that cycle: en=1 reloads, en=0 freezes.
        assign expire  = en_q && tick && !tcfg_we && (cnt_q == '0);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                en_q   <= 1'b0;
                per_q  <= 1'b0;
                init_q <= '0;
                cnt_q  <= '1;
                pend_q <= 1'b0;
            end else begin
                if (tcfg_we) begin
                    en_q   <= cfg_new[0];
                    per_q  <= cfg_new[1];
                    init_q <= cfg_new[CNT_W-1:2];
                    if (cfg_new[0]) begin
                        cnt_q <= {cfg_new[CNT_W-1:2], 2'b00};
                    end
                end else if (en_q && tick && (cnt_q != '1)) begin
                    if (cnt_q == '0) begin
                        cnt_q <= per_q ? {init_q, 2'b00} : '1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                if (expire) begin
                    pend_q <= 1'b1;
                end else if (clr_we) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign cnt_arr[i] = cnt_q;
        assign cfg_arr[i] = cfg_old;
        assign pend_v[i]  = pend_q;
    end

    always_comb begin
        csr_rvalue = '0;
        if (is_tpre) begin
            csr_rvalue = 32'(tpre);
        end else if (is_tie) begin
            csr_rvalue = 32'(tie);
        end else if (is_chan) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 12'(i)) begin
                    case (slot)
                        2'd0:    csr_rvalue = 32'(cfg_arr[i]);
                        2'd1:    csr_rvalue = 32'(cnt_arr[i]);
                        2'd2:    csr_rvalue = 32'(pend_v[i]);
                        default: csr_rvalue = '0;
                    endcase
                end
            end
        end
    end

    // Scan from the top so the lowest enabled pending channel is the last to write irq_id.
    assign masked = pend_v & tie;
    always_comb begin
        irq_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (masked[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    assign irq_any    = |masked;
    assign timer_pend = pend_v;
    assign csr_hit    = in_map;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: directed scenarios with literal expectations plus random CSR traffic
// compared every cycle against an arithmetic model of the timer bank.
module tb_csr_timer_bank;

    localparam int    NUM_CH = 4;
    localparam int    BASE   = 'h40;
    localparam int    GLOB   = BASE + 4 * NUM_CH;
    localparam longint ALL   = 64'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              resetn;
    logic [13:0]       csr_num;
    logic              csr_we;
    logic [31:0]       csr_wmask;
    logic [31:0]       csr_wvalue;
    logic [31:0]       csr_rvalue;
    logic              csr_hit;
    logic [NUM_CH-1:0] timer_pend;
    logic              irq_any;
    logic [2:0]        irq_id;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    bit     m_en   [NUM_CH];
    bit     m_per  [NUM_CH];
    bit     m_pend [NUM_CH];
    longint m_init [NUM_CH];
    longint m_cnt  [NUM_CH];
    int     m_tpre;
    int     m_tie;
    longint m_since;

    csr_timer_bank dut (
        .clk        (clk),
        .resetn     (resetn),
        .csr_num    (csr_num),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_rvalue (csr_rvalue),
        .csr_hit    (csr_hit),
        .timer_pend (timer_pend),
        .irq_any    (irq_any),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] m, logic [31:0] v);
        return (m & v) | (~m & old);
    endfunction

    function automatic logic [31:0] model_read(logic [13:0] num);
        int off;
        int ch;
        off = int'(num) - BASE;
        if (off < 0 || off > 4 * NUM_CH + 1) return 32'h0;
        if (off == 4 * NUM_CH) return 32'(m_tpre);
        if (off == 4 * NUM_CH + 1) return 32'(m_tie);
        ch = off / 4;
        case (off % 4)
            0:       return 32'(m_init[ch] * 4 + (m_per[ch] ? 2 : 0) + (m_en[ch] ? 1 : 0));
            1:       return 32'(m_cnt[ch]);
            2:       return m_pend[ch] ? 32'h1 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_hit(logic [13:0] num);
        int off;
        off = int'(num) - BASE;
        return (off >= 0) && (off <= 4 * NUM_CH + 1);
    endfunction

    function automatic logic [NUM_CH-1:0] model_pend();
        logic [NUM_CH-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_CH; i++) p[i] = m_pend[i];
        return p;
    endfunction

    function automatic int model_irq_id();
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_pend[i] && m_tie[i]) return i;
        end
        return 0;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_CH; i++) begin
            m_en[i]   = 1'b0;
            m_per[i]  = 1'b0;
            m_pend[i] = 1'b0;
            m_init[i] = 0;
            m_cnt[i]  = ALL;
        end
        m_tpre  = 0;
        m_tie   = 0;
        m_since = 0;
    endtask

    // One clock edge of the bank expressed as arithmetic on the model state.
    task automatic step_model();
        int          off;
        bit          wr_tpre;
        bit          wr_tie;
        bit          tick;
        bit          wr_cfg;
        bit          wr_clr;
        bit          expired;
        logic [31:0] nv;
        off     = int'(csr_num) - BASE;
        wr_tpre = csr_we && (off == 4 * NUM_CH);
        wr_tie  = csr_we && (off == 4 * NUM_CH + 1);
        tick    = ((m_since % (m_tpre + 1)) == m_tpre) && !wr_tpre;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_cfg  = csr_we && (off == 4 * ch);
            wr_clr  = csr_we && (off == 4 * ch + 2) && csr_wmask[0] && csr_wvalue[0];
            expired = 1'b0;
            if (wr_cfg) begin
                nv = merge(model_read(14'(BASE + 4 * ch)), csr_wmask, csr_wvalue);
                m_en[ch]   = nv[0];
                m_per[ch]  = nv[1];
                m_init[ch] = longint'(nv[31:2]);
                if (m_en[ch]) m_cnt[ch] = m_init[ch] * 4;
            end else if (m_en[ch] && tick && m_cnt[ch] != ALL) begin
                if (m_cnt[ch] == 0) begin
                    expired   = 1'b1;
                    m_cnt[ch] = m_per[ch] ? m_init[ch] * 4 : ALL;
                end else begin
                    m_cnt[ch] = m_cnt[ch] - 1;
                end
            end
            if (expired) m_pend[ch] = 1'b1;
            else if (wr_clr) m_pend[ch] = 1'b0;
        end
        if (wr_tpre) begin
            nv      = merge(32'(m_tpre), csr_wmask, csr_wvalue);
            m_tpre  = int'(nv[7:0]);
            m_since = 0;
        end else begin
            m_since = m_since + 1;
        end
        if (wr_tie) begin
            nv    = merge(32'(m_tie), csr_wmask, csr_wvalue);
            m_tie = int'(nv[NUM_CH-1:0]);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) reset_model();
        else step_model();
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cmp_pend",   32'(timer_pend), 32'(model_pend()));
            checkOutput("cmp_irqany", 32'(irq_any),    (model_pend() & NUM_CH'(m_tie)) != 0 ? 32'h1 : 32'h0);
            checkOutput("cmp_irqid",  32'(irq_id),     32'(model_irq_id()));
            checkOutput("cmp_hit",    32'(csr_hit),    32'(model_hit(csr_num)));
            checkOutput("cmp_rvalue", csr_rvalue,      model_read(csr_num));
        end
    end

    task automatic applyStimulus(logic [13:0] num, logic we, logic [31:0] mask, logic [31:0] val);
        csr_num    = num;
        csr_we     = we;
        csr_wmask  = mask;
        csr_wvalue = val;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic setRead(logic [13:0] num);
        csr_num    = num;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        resetn     = 1'b1;
        csr_num    = '0;
        csr_we     = 1'b0;
        csr_wmask  = '0;
        csr_wvalue = '0;
        #1 resetn = 1'b0;
        csr_num = 14'h41;
        #1;
        checkOutput("rst_tval", csr_rvalue, 32'hFFFF_FFFF);
        checkOutput("rst_pend", 32'(timer_pend), 32'h0);
        checkOutput("rst_irq",  {28'h0, irq_any, irq_id}, 32'h0);
        #20 resetn = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;

        // One-shot countdown from 16 with TPRE=0
        applyStimulus(14'h40, 1'b1, 32'hFFFF_FFFF, 32'h11);
        setRead(14'h41);
        checkOutput("t1_load", csr_rvalue, 32'd16);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            checkOutput("t1_count", csr_rvalue, 32'(16 - k));
        end
        idle(1);
        checkOutput("t1_wrap", csr_rvalue, 32'hFFFF_FFFF);
        checkOutput("t1_pend", 32'(timer_pend[0]), 32'h1);
        idle(3);
        checkOutput("t1_hold", csr_rvalue, 32'hFFFF_FFFF);

        // Periodic channel 2 behind a divide-by-4 prescaler
        applyStimulus(14'(GLOB), 1'b1, 32'hFFFF_FFFF, 32'h3);
        applyStimulus(14'h48, 1'b1, 32'hFFFF_FFFF, 32'h0B);
        setRead(14'h49);
        checkOutput("t2_load", csr_rvalue, 32'd8);
        idle(40);
        checkOutput("t2_pend", 32'(timer_pend[2]), 32'h1);
        applyStimulus(14'h4A, 1'b1, 32'h1, 32'h1);
        checkOutput("t2_clear", 32'(timer_pend[2]), 32'h0);

        // Clear colliding with expiry on the same edge
        applyStimulus(14'(GLOB), 1'b1, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(14'h42, 1'b1, 32'h1, 32'h1);
        checkOutput("t3_pre_clr", 32'(timer_pend[0]), 32'h0);
        applyStimulus(14'h40, 1'b1, 32'hFFFF_FFFF, 32'h01);
        setRead(14'h41);
        checkOutput("t3_zero", csr_rvalue, 32'h0);
        applyStimulus(14'h42, 1'b1, 32'h1, 32'h1);
        checkOutput("t3_setwins", 32'(timer_pend[0]), 32'h1);
        applyStimulus(14'h42, 1'b1, 32'h1, 32'h1);
        checkOutput("t3_cleared", 32'(timer_pend[0]), 32'h0);

        // Priority encoder with channels 1 and 3 pending
        applyStimulus(14'h48, 1'b1, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(14'h4A, 1'b1, 32'h1, 32'h1);
        applyStimulus(14'h44, 1'b1, 32'hFFFF_FFFF, 32'h01);
        applyStimulus(14'h4C, 1'b1, 32'hFFFF_FFFF, 32'h01);
        idle(2);
        checkOutput("t4_pend", 32'(timer_pend), 32'hA);
        applyStimulus(14'(GLOB + 1), 1'b1, 32'hFFFF_FFFF, 32'hA);
        checkOutput("t4_any_a", 32'(irq_any), 32'h1);
        checkOutput("t4_id_a",  32'(irq_id),  32'h1);
        applyStimulus(14'(GLOB + 1), 1'b1, 32'hFFFF_FFFF, 32'h8);
        checkOutput("t4_id_8", 32'(irq_id), 32'h3);
        applyStimulus(14'(GLOB + 1), 1'b1, 32'hFFFF_FFFF, 32'h0);
        checkOutput("t4_any_0",  32'(irq_any),    32'h0);
        checkOutput("t4_id_0",   32'(irq_id),     32'h0);
        checkOutput("t4_pend_0", 32'(timer_pend), 32'hA);

        // Masked writes to the enable bit only
        applyStimulus(14'h40, 1'b1, 32'hFFFF_FFFF, 32'h0F);
        setRead(14'h41);
        checkOutput("t5_load", csr_rvalue, 32'd12);
        idle(3);
        checkOutput("t5_run", csr_rvalue, 32'd9);
        applyStimulus(14'h40, 1'b1, 32'h1, 32'h0);
        setRead(14'h41);
        checkOutput("t5_frozen", csr_rvalue, 32'd9);
        setRead(14'h40);
        checkOutput("t5_cfg", csr_rvalue, 32'h0E);
        setRead(14'h41);
        idle(2);
        checkOutput("t5_still", csr_rvalue, 32'd9);
        applyStimulus(14'h40, 1'b1, 32'h1, 32'h1);
        setRead(14'h41);
        checkOutput("t5_reload", csr_rvalue, 32'd12);

        // Random CSR traffic compared against the model every cycle
        for (int n = 0; n < 3000; n++) begin
            logic [13:0] num;
            logic [31:0] mask;
            logic [31:0] val;
            if ($urandom_range(0, 9) < 8) num = 14'(BASE - 2 + int'($urandom_range(0, 4 * NUM_CH + 3)));
            else num = 14'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            val  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3F);
            applyStimulus(num, ($urandom_range(0, 3) == 0), mask, val);
        end

        // Asynchronous reset in the middle of a countdown
        applyStimulus(14'(GLOB), 1'b1, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(14'h40, 1'b1, 32'hFFFF_FFFF, 32'h41);
        setRead(14'h41);
        idle(3);
        #1 resetn = 1'b0;
        #1;
        checkOutput("t6_tval", csr_rvalue, 32'hFFFF_FFFF);
        checkOutput("t6_irq",  32'(irq_any), 32'h0);
        checkOutput("t6_pend", 32'(timer_pend), 32'h0);
        idle(1);
        setRead(14'h3F);
        checkOutput("t6_rd_3f",  csr_rvalue, 32'h0);
        checkOutput("t6_hit_3f", 32'(csr_hit), 32'h0);
        idle(1);
        setRead(14'(GLOB + 2));
        checkOutput("t6_rd_g2",  csr_rvalue, 32'h0);
        checkOutput("t6_hit_g2", 32'(csr_hit), 32'h0);
        idle(1);
        setRead(14'h43);
        checkOutput("t6_rd_rsv",  csr_rvalue, 32'h0);
        checkOutput("t6_hit_rsv", 32'(csr_hit), 32'h1);
        #1 resetn = 1'b1;
        idle(5);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
